// File: rtl/pipeline_ctrl.sv
// Pipeline control sequencer for the 5-stage core: turns hazard, branch and memory
// handshakes into per-stage enable/flush controls and keeps saturating stall/flush counters.
module pipeline_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_use_hazard,
   input  logic             branch_taken,
   input  logic             imem_ready,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   input  logic             clr_cnt,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             idex_en,
   output logic             exmem_en,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             memwb_flush,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      MEM_WAIT  = 2'd1,
      REDIRECT  = 2'd2,
      LU_BUBBLE = 2'd3
   } state_t;

   state_t state_reg, state_next;

   logic mem_stall;
   logic br_act;
   logic lu_act;
   logic redirect_evt;

   // REDIRECT holds bubbles in ID/EX, so branch and hazard inputs are stale there;
   // LU_BUBBLE ignores the hazard so each hazard costs exactly one bubble.
   assign mem_stall = dmem_req && !dmem_ready;
   assign br_act    = branch_taken && ((state_reg == RUN) || (state_reg == LU_BUBBLE));
   assign lu_act    = load_use_hazard && (state_reg == RUN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= RUN;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         MEM_WAIT: begin
            if (dmem_ready) state_next = RUN;
         end
         default: begin
            if (mem_stall)   state_next = MEM_WAIT;
            else if (br_act) state_next = REDIRECT;
            else if (lu_act) state_next = LU_BUBBLE;
            else             state_next = RUN;
         end
      endcase
   end

   always_comb begin
      pc_en        = 1'b1;
      ifid_en      = 1'b1;
      idex_en      = 1'b1;
      exmem_en     = 1'b1;
      ifid_flush   = 1'b0;
      idex_flush   = 1'b0;
      memwb_flush  = 1'b0;
      redirect_evt = 1'b0;
      case (state_reg)
         MEM_WAIT: begin
            if (!dmem_ready) begin
               pc_en       = 1'b0;
               ifid_en     = 1'b0;
               idex_en     = 1'b0;
               exmem_en    = 1'b0;
               memwb_flush = 1'b1;
            end
         end
         default: begin
            if (mem_stall) begin
               pc_en       = 1'b0;
               ifid_en     = 1'b0;
               idex_en     = 1'b0;
               exmem_en    = 1'b0;
               memwb_flush = 1'b1;
            end else if (br_act) begin
               ifid_flush   = 1'b1;
               idex_flush   = 1'b1;
               redirect_evt = 1'b1;
            end else if (lu_act) begin
               pc_en      = 1'b0;
               ifid_en    = 1'b0;
               idex_flush = 1'b1;
            end else if (!imem_ready) begin
               pc_en      = 1'b0;
               ifid_flush = 1'b1;
            end
         end
      endcase
      // Reset drives a safe frozen pipeline full of bubbles regardless of state.
      if (!rst_n) begin
         pc_en       = 1'b0;
         ifid_en     = 1'b0;
         idex_en     = 1'b0;
         exmem_en    = 1'b0;
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         memwb_flush = 1'b1;
      end
   end

   assign state = state_reg;

   logic [1:0]       cnt_inc;
   logic [CNT_W-1:0] cnt_reg [2];

   assign cnt_inc[0] = !pc_en;
   assign cnt_inc[1] = redirect_evt;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
               cnt_reg[gi] <= '0;
            else if (clr_cnt)
               cnt_reg[gi] <= '0;
            else if (cnt_inc[gi] && (cnt_reg[gi] != {CNT_W{1'b1}}))
               cnt_reg[gi] <= cnt_reg[gi] + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   endgenerate

   assign stall_cnt = cnt_reg[0];
   assign flush_cnt = cnt_reg[1];

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Pipeline control sequencer for the 5-stage core. It consumes the hazard unit's `load_use_hazard` and the EX-stage branch resolution. It also consumes the instruction- and data-memory ready handshakes. From these it drives the per-stage enable/flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB, and keeps saturating stall/flush performance counters.

## Interface
- `CNT_W`, default 32: width of the performance counters.

- `clk`  in  1  single core clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `load_use_hazard`  in  1  ID instruction consumes the EX-stage load destination.
- `branch_taken`  in  1  EX stage resolved a taken branch/jump; redirect required.
- `imem_ready`  in  1  fetch data valid this cycle.
- `dmem_req`  in  1  MEM stage holds a load/store.
- `dmem_ready`  in  1  data memory completes the MEM access this cycle.
- `clr_cnt`  in  1  synchronous clear of both counters.
- `pc_en`, `ifid_en`, `idex_en`, `exmem_en`  out  1 each  register load enables.
- `ifid_flush`, `idex_flush`, `memwb_flush`  out  1 each  load a bubble (NOP) into that register.
- `state`  out  2  FSM state, debug only.
- `stall_cnt`  out  CNT_W  cycles with `pc_en`=0.
- `flush_cnt`  out  CNT_W  branch redirects taken.

## Operation
- FSM states: RUN=0, MEM_WAIT=1, REDIRECT=2, LU_BUBBLE=3. Reset state is RUN.
- Control outputs are Mealy: combinational from the current state and inputs.
- Default (no condition active): all enables 1, all flushes 0.
- In RUN, LU_BUBBLE and REDIRECT the conditions below are evaluated in priority order, highest first; only the highest active one applies.
  1. `dmem_req && !dmem_ready`: all four enables 0; `memwb_flush`=1. Next state MEM_WAIT.
  2. `branch_taken`: `pc_en`=1; `ifid_flush`=`idex_flush`=1. Next state REDIRECT. `flush_cnt` increments.
  3. `load_use_hazard`: `pc_en`=`ifid_en`=0; `idex_flush`=1; `exmem_en`=1. Next state LU_BUBBLE.
  4. `!imem_ready`: `pc_en`=0; `ifid_flush`=1; others default. Stay/return to RUN.
  5. Otherwise: default outputs. Next state RUN.
- MEM_WAIT:
  - While `!dmem_ready`: all enables 0, `memwb_flush`=1.
  - When `dmem_ready`=1: default outputs, next state RUN.
  - `branch_taken` is ignored in this state. The EX instruction is frozen, so it is re-evaluated after return to RUN.
- REDIRECT lasts one cycle:
  - `branch_taken` and `load_use_hazard` are ignored, because EX and ID hold bubbles.
  - Priorities 1 and 4 still apply.
  - Next state RUN, or MEM_WAIT under priority 1.
- LU_BUBBLE lasts one cycle:
  - `load_use_hazard` is ignored, which guarantees exactly one bubble per hazard.
  - Priorities 1, 2 and 4 apply.
  - Next state is RUN, MEM_WAIT or REDIRECT accordingly.
- Counters:
  - `stall_cnt` +1 on each cycle with `pc_en`=0.
  - `flush_cnt` +1 on each priority-2 redirect.
  - Both saturate at 2^CNT_W-1 (no wrap).
  - `clr_cnt` zeros both and takes priority over a same-cycle increment.

## Timing
- While `rst_n`=0:
  - state=RUN; counters=0.
  - Controls forced to enables 0 and flushes 1 (`ifid_flush`=`idex_flush`=`memwb_flush`=1).
  - Asserting reset mid-MEM_WAIT or mid-REDIRECT aborts immediately, asynchronously.
- First cycle after deassertion: RUN with default outputs (given `imem_ready`=1).
- Timing of each case:
  - Load-use: exactly 1 bubble cycle.
  - Taken branch: 2-cycle penalty; the new-target fetch is in IF on the cycle after the redirect.
  - Data-memory wait: N wait cycles freeze the pipeline for N cycles; it resumes the cycle `dmem_ready` is seen.
- Simultaneous events follow the priority list:
  - dmem stall masks a branch.
  - A branch plus a load-use hazard gives a redirect only; no bubble, and `stall_cnt` does not increment.
- Counter outputs are registered; they reflect the increment one cycle after the event.

## Test plan
- Reset: hold `rst_n`=0 with random inputs → all enables 0, all flushes 1, `state`=0, counters 0. Release → default outputs next cycle.
- Load-use: pulse `load_use_hazard` 1 cycle in RUN → cycle 0 has `pc_en`=0, `idex_flush`=1, `state`→3. Hold the hazard high 2 cycles → only 1 bubble. `stall_cnt`=1.
- Branch: `branch_taken` with `load_use_hazard` both 1 → `ifid_flush`=`idex_flush`=1, `pc_en`=1, next `state`=2. Branch held in REDIRECT is ignored. `flush_cnt`=1.
- Memory wait: `dmem_req`=1, `dmem_ready`=0 for 3 cycles together with `branch_taken`=1 → 3 frozen cycles with `memwb_flush`=1. Then branch redirect on return to RUN. `stall_cnt`=3.
- Saturation/clear: CNT_W=4, 20 stall cycles → `stall_cnt`=15. `clr_cnt` on a stall cycle → 0.
- Async reset mid-MEM_WAIT → state 0 immediately, without waiting for a clock edge.
